// File: rtl/char_plane_writer.sv
// char_plane_writer: write-side controller for the 16x32 character plane.
// Takes a valid/ready byte stream of character IDs, keeps a text cursor,
// handles CR/LF/FF (and optionally BS) and drives the plane's write port.
// All plane-write and cursor outputs are registered.
// Optional feature macro: CHAR_PLANE_BACKSPACE_EN. When it is defined,
// 0x08 moves the cursor back and blanks the cell. Otherwise 0x08 is printable.
module char_plane_writer #(
  parameter int ROW_NUMBER     = 16,
  parameter int COL_NUMBER     = 32,
  parameter int ROW_BIT_LEN    = 4,
  parameter int COL_BIT_LEN    = 5,
  parameter int CHAR_ID_LENGTH = 8,
  parameter logic [CHAR_ID_LENGTH-1:0] BLANK_ID = 8'h20
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHAR_ID_LENGTH-1:0] char_in,
  input  logic                      char_valid,
  output logic                      char_ready,
  output logic [CHAR_ID_LENGTH-1:0] wr_data,
  output logic [ROW_BIT_LEN-1:0]    wr_row,
  output logic [COL_BIT_LEN-1:0]    wr_col,
  output logic                      wr_we,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam logic [ROW_BIT_LEN-1:0] ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [ROW_BIT_LEN-1:0] ROW_ONE  = ROW_BIT_LEN'(1);
  localparam logic [COL_BIT_LEN-1:0] COL_ONE  = COL_BIT_LEN'(1);

  localparam logic [CHAR_ID_LENGTH-1:0] CODE_CR = CHAR_ID_LENGTH'('h0D);
  localparam logic [CHAR_ID_LENGTH-1:0] CODE_LF = CHAR_ID_LENGTH'('h0A);
  localparam logic [CHAR_ID_LENGTH-1:0] CODE_FF = CHAR_ID_LENGTH'('h0C);
`ifdef CHAR_PLANE_BACKSPACE_EN
  localparam logic [CHAR_ID_LENGTH-1:0] CODE_BS = CHAR_ID_LENGTH'('h08);
`endif

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2
  } state_t;

  state_t state, state_next;

  // Clear walker: clr_end marks that the final cell has already been issued,
  // so the next cycle only returns to IDLE.
  logic [ROW_BIT_LEN-1:0]    clr_row, clr_row_next;
  logic [COL_BIT_LEN-1:0]    clr_col, clr_col_next;
  logic                      clr_end, clr_end_next;

  logic [ROW_BIT_LEN-1:0]    cur_row_next;
  logic [COL_BIT_LEN-1:0]    cur_col_next;
  logic                      we_next;
  logic [CHAR_ID_LENGTH-1:0] data_next;
  logic [ROW_BIT_LEN-1:0]    row_next;
  logic [COL_BIT_LEN-1:0]    col_next;

  logic [ROW_BIT_LEN-1:0]    row_inc;
  logic                      accept;

  assign char_ready = (state == IDLE) && reset_n;
  assign busy       = (state != IDLE);
  assign accept     = char_valid && (state == IDLE);
  assign row_inc    = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_ONE;

  // State, cursor, clear walker and registered write port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= CLEAR_ALL;
      cursor_row <= '0;
      cursor_col <= '0;
      clr_row    <= '0;
      clr_col    <= '0;
      clr_end    <= 1'b0;
      wr_we      <= 1'b0;
      wr_data    <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
    end else begin
      state      <= state_next;
      cursor_row <= cur_row_next;
      cursor_col <= cur_col_next;
      clr_row    <= clr_row_next;
      clr_col    <= clr_col_next;
      clr_end    <= clr_end_next;
      wr_we      <= we_next;
      wr_data    <= data_next;
      wr_row     <= row_next;
      wr_col     <= col_next;
    end
  end

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_next   = state;
    cur_row_next = cursor_row;
    cur_col_next = cursor_col;
    clr_row_next = clr_row;
    clr_col_next = clr_col;
    clr_end_next = clr_end;
    we_next      = 1'b0;
    data_next    = wr_data;
    row_next     = wr_row;
    col_next     = wr_col;

    unique case (state)
      CLEAR_ALL: begin
        if (clr_end) begin
          state_next = IDLE;
        end else begin
          we_next   = 1'b1;
          data_next = BLANK_ID;
          row_next  = clr_row;
          col_next  = clr_col;
          if (clr_col == COL_LAST) begin
            clr_col_next = '0;
            if (clr_row == ROW_LAST) begin
              clr_end_next = 1'b1;
            end else begin
              clr_row_next = clr_row + ROW_ONE;
            end
          end else begin
            clr_col_next = clr_col + COL_ONE;
          end
        end
      end

      CLEAR_LINE: begin
        if (clr_end) begin
          state_next = IDLE;
        end else begin
          we_next   = 1'b1;
          data_next = BLANK_ID;
          row_next  = cursor_row;
          col_next  = clr_col;
          if (clr_col == COL_LAST) begin
            clr_col_next = '0;
            clr_end_next = 1'b1;
          end else begin
            clr_col_next = clr_col + COL_ONE;
          end
        end
      end

      IDLE: begin
        if (accept) begin
          case (char_in)
            CODE_CR: begin
              cur_col_next = '0;
            end
            CODE_LF: begin
              cur_col_next = '0;
              cur_row_next = row_inc;
              state_next   = CLEAR_LINE;
              clr_col_next = '0;
              clr_end_next = 1'b0;
            end
            CODE_FF: begin
              cur_row_next = '0;
              cur_col_next = '0;
              state_next   = CLEAR_ALL;
              clr_row_next = '0;
              clr_col_next = '0;
              clr_end_next = 1'b0;
            end
`ifdef CHAR_PLANE_BACKSPACE_EN
            CODE_BS: begin
              // Backspace never crosses into the previous row.
              if (cursor_col != '0) begin
                cur_col_next = cursor_col - COL_ONE;
                we_next      = 1'b1;
                data_next    = BLANK_ID;
                row_next     = cursor_row;
                col_next     = cursor_col - COL_ONE;
              end
            end
`endif
            default: begin
              we_next   = 1'b1;
              data_next = char_in;
              row_next  = cursor_row;
              col_next  = cursor_col;
              if (cursor_col == COL_LAST) begin
                // Glyph in the last column behaves as glyph followed by LF.
                cur_col_next = '0;
                cur_row_next = row_inc;
                state_next   = CLEAR_LINE;
                clr_col_next = '0;
                clr_end_next = 1'b0;
              end else begin
                cur_col_next = cursor_col + COL_ONE;
              end
            end
          endcase
        end
      end

      default: begin
        state_next = CLEAR_ALL;
      end
    endcase
  end

endmodule

// File: tb/tb_char_plane_writer.sv
// Directed testbench for char_plane_writer. Build with or without
// CHAR_PLANE_BACKSPACE_EN to match the DUT build.
module tb_char_plane_writer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] wr_data;
  logic [3:0] wr_row;
  logic [4:0] wr_col;
  logic       wr_we;
  logic [3:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Write log entries are {row, col, data}.
  logic [16:0] wlog[$];
  logic [7:0]  mem [16][32];

  char_plane_writer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .wr_data    (wr_data),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_we      (wr_we),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Plane model: records every presented write.
  always @(negedge clock) begin
    if (wr_we) begin
      wlog.push_back({wr_row, wr_col, wr_data});
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  function automatic logic [16:0] log_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return 17'h1FFFF;
  endfunction

  // Present a byte, wait for ready (bounded), let it transfer, drop valid.
  task automatic send_byte(input logic [7:0] b);
    int n;
    char_in    = b;
    char_valid = 1'b1;
    n = 0;
    while (!char_ready && n < 1000) begin
      tick();
      n++;
    end
    if (!char_ready) check("send_ready_timeout", char_ready, 1);
    tick();
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!char_ready && n < 1000) begin
      tick();
      n++;
    end
    if (!char_ready) check("idle_timeout", char_ready, 1);
  endtask

  // Expects exactly 512 blank writes in row-major order in the log.
  task automatic check_full_clear(input string tag);
    int bad;
    logic [16:0] e;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      e = {i[8:5], i[4:0], 8'h20};
      if (log_at(i) !== e) bad++;
    end
    check({tag, "_count"}, wlog.size(), 512);
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic count_to_ready(input string tag, input int exp);
    int n;
    n = 0;
    while (!char_ready && n < 1000) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    reset_n    = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        mem[r][c] = 8'hFF;
    @(negedge clock); #1;

    // Reset held for 3 cycles.
    tick(); tick(); tick();
    check("rst_ready", char_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_we", wr_we, 0);
    check("rst_wr_port", {wr_data, wr_row, wr_col}, 0);
    check("rst_cursor", {cursor_row, cursor_col}, 0);

    // Release: 512 blank writes, ready on edge 513.
    wlog.delete();
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!char_ready && n < 600);
    check("init_ready_cycle", n, 513);
    check_full_clear("init_clear");
    check("init_cursor", {cursor_row, cursor_col}, 0);
    check("init_busy", busy, 0);

    // "AB" back to back.
    char_valid = 1'b1;
    char_in    = 8'h41;
    tick();
    check("a_write", {wr_we, wr_row, wr_col, wr_data}, {1'b1, 4'd0, 5'd0, 8'h41});
    check("a_cursor", {cursor_row, cursor_col}, {4'd0, 5'd1});
    check("a_ready", char_ready, 1);
    char_in = 8'h42;
    tick();
    check("b_write", {wr_we, wr_row, wr_col, wr_data}, {1'b1, 4'd0, 5'd1, 8'h42});
    check("b_cursor", {cursor_row, cursor_col}, {4'd0, 5'd2});
    check("b_ready", char_ready, 1);
    char_valid = 1'b0;
    tick();
    check("ab_we_off", wr_we, 0);

    // Fill to (0,31), then a glyph in the last column.
    for (int i = 0; i < 29; i++) send_byte(8'h61);
    tick();
    check("col31_cursor", {cursor_row, cursor_col}, {4'd0, 5'd31});
    wlog.delete();
    send_byte(8'h5A);
    check("last_glyph", {wr_we, wr_row, wr_col, wr_data}, {1'b1, 4'd0, 5'd31, 8'h5A});
    check("last_cursor", {cursor_row, cursor_col}, {4'd1, 5'd0});
    check("last_ready_low", char_ready, 0);
    check("last_busy", busy, 1);
    count_to_ready("last_ready_wait", 33);
    check("last_log_size", wlog.size(), 33);
    bad = 0;
    for (int c = 0; c < 32; c++)
      if (log_at(c + 1) !== {4'd1, c[4:0], 8'h20}) bad++;
    check("last_line_clear", bad, 0);

    // Move to (15,5) and send LF with valid held through the clear.
    for (int i = 0; i < 14; i++) send_byte(8'h0A);
    wait_idle();
    for (int i = 0; i < 5; i++) send_byte(8'h2E);
    tick();
    check("r15_cursor", {cursor_row, cursor_col}, {4'd15, 5'd5});
    char_in    = 8'h0A;
    char_valid = 1'b1;
    tick();
    check("lf_wrap_cursor", {cursor_row, cursor_col}, 0);
    check("lf_state_busy", busy, 1);
    char_in = 8'h51;
    count_to_ready("lf_ready_wait", 33);
    check("lf_held_cursor", {cursor_row, cursor_col}, 0);
    tick();
    check("q_write", {wr_we, wr_row, wr_col, wr_data}, {1'b1, 4'd0, 5'd0, 8'h51});
    check("q_cursor", {cursor_row, cursor_col}, {4'd0, 5'd1});
    char_valid = 1'b0;
    tick();
    bad = 0;
    for (int c = 1; c < 32; c++)
      if (mem[0][c] !== 8'h20) bad++;
    check("row0_cleared", bad, 0);
    check("row0_q", mem[0][0], 8'h51);

    // Backspace behaviour at (3,4).
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    wait_idle();
    for (int i = 0; i < 4; i++) send_byte(8'h62);
    tick();
    check("bs_start_cursor", {cursor_row, cursor_col}, {4'd3, 5'd4});
    send_byte(8'h08);
`ifdef CHAR_PLANE_BACKSPACE_EN
    check("bs_write", {wr_we, wr_row, wr_col, wr_data}, {1'b1, 4'd3, 5'd3, 8'h20});
    check("bs_cursor", {cursor_row, cursor_col}, {4'd3, 5'd3});
`else
    check("bs_write", {wr_we, wr_row, wr_col, wr_data}, {1'b1, 4'd3, 5'd4, 8'h08});
    check("bs_cursor", {cursor_row, cursor_col}, {4'd3, 5'd5});
`endif
    send_byte(8'h0D);
    check("cr_no_write", wr_we, 0);
    check("cr_cursor", {cursor_row, cursor_col}, {4'd3, 5'd0});
    check("cr_ready", char_ready, 1);
`ifdef CHAR_PLANE_BACKSPACE_EN
    send_byte(8'h08);
    check("bs0_no_write", wr_we, 0);
    check("bs0_cursor", {cursor_row, cursor_col}, {4'd3, 5'd0});
    check("bs0_ready", char_ready, 1);
`endif

    // FF from (7,9), reset after 100 clear cycles.
    for (int i = 0; i < 4; i++) send_byte(8'h0A);
    wait_idle();
    for (int i = 0; i < 9; i++) send_byte(8'h63);
    tick();
    check("ff_start_cursor", {cursor_row, cursor_col}, {4'd7, 5'd9});
    wlog.delete();
    send_byte(8'h0C);
    check("ff_cursor", {cursor_row, cursor_col}, 0);
    check("ff_busy", busy, 1);
    check("ff_ready", char_ready, 0);
    for (int i = 0; i < 100; i++) tick();
    check("ff_partial_count", wlog.size(), 100);
    reset_n = 1'b0;
    tick(); tick();
    check("mid_rst_we", wr_we, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_ready", char_ready, 0);
    wlog.delete();
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!char_ready && n < 600);
    check("restart_ready_cycle", n, 513);
    check_full_clear("restart_clear");
    tick();
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        if (mem[r][c] !== 8'h20) bad++;
    check("plane_all_blank", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
